// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: motion controller for the line-tracking car.
//   Synchronises and debounces the three IR track sensors, runs the
//   stop/forward/turn/search/halt policy and drives both motor PWMs.
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   enable       run request; 0 forces IDLE
//   left_track   raw left sensor   (0 = line under sensor)
//   mid_track    raw middle sensor (0 = line)
//   right_track  raw right sensor  (0 = line)
//   state        action code: 00 stop, 01 left, 10 right, 11 forward
//   left_pwm     left motor PWM
//   right_pwm    right motor PWM
//   lost         1 while halted after a failed search
//   line_pattern debounced {left,mid,right}
module line_follow_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SEARCH_TIMEOUT  = 50_000_000,
    parameter int unsigned PWM_PERIOD      = 1024,
    parameter int unsigned FWD_DUTY        = 800,
    parameter int unsigned TURN_FAST       = 900,
    parameter int unsigned TURN_SLOW       = 300,
    parameter int unsigned SEARCH_DUTY     = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       left_track,
    input  logic       mid_track,
    input  logic       right_track,
    output logic [1:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       lost,
    output logic [2:0] line_pattern
);
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TMR_W = (SEARCH_TIMEOUT > 2) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int unsigned CNT_W = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
    localparam int unsigned DTY_W = CNT_W + 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

    // Duties at or above the period saturate to PWM_PERIOD, which keeps the output constantly high.
    function automatic logic [DTY_W-1:0] sat_duty(input int unsigned d);
        return (d >= PWM_PERIOD) ? DTY_W'(PWM_PERIOD) : DTY_W'(d);
    endfunction

    localparam logic [DTY_W-1:0] D_FWD  = sat_duty(FWD_DUTY);
    localparam logic [DTY_W-1:0] D_FAST = sat_duty(TURN_FAST);
    localparam logic [DTY_W-1:0] D_SLOW = sat_duty(TURN_SLOW);
    localparam logic [DTY_W-1:0] D_SRCH = sat_duty(SEARCH_DUTY);

    typedef enum logic [2:0] {S_IDLE, S_FWD, S_TURN_L, S_TURN_R, S_SEARCH, S_HALT} fsm_e;
    typedef enum logic [2:0] {P_FWD, P_TURN_L, P_TURN_R, P_LOST, P_HOLD} dec_e;

    // ---------------- input synchroniser and debounce ----------------
    logic [2:0]      sync1_q, sync2_q, pattern_q;
    logic [DB_W-1:0] db_cnt_q;

    // sync1 != sync2 means the synced vector changes on this edge, so the
    // stability count restarts on the same edge the new value arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_cnt_q  <= '0;
            pattern_q <= '1;
        end else begin
            sync1_q <= {left_track, mid_track, right_track};
            sync2_q <= sync1_q;
            if (sync1_q != sync2_q)
                db_cnt_q <= '0;
            else if (db_cnt_q != DB_LAST)
                db_cnt_q <= db_cnt_q + 1'b1;
            if (db_cnt_q == DB_LAST)
                pattern_q <= sync2_q;
        end
    end

    // ---------------- pattern decode ----------------
    dec_e dec;

    always_comb begin
        dec = P_HOLD;
        unique case (pattern_q)
            3'b101, 3'b000: dec = P_FWD;
            3'b011, 3'b001: dec = P_TURN_L;
            3'b110, 3'b100: dec = P_TURN_R;
            3'b111:         dec = P_LOST;
            default:        dec = P_HOLD;
        endcase
    end

    // ---------------- policy FSM ----------------
    fsm_e             fsm_q, fsm_d;
    logic             dir_left_q, dir_left_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    always_comb begin
        fsm_d      = fsm_q;
        dir_left_d = dir_left_q;
        timer_d    = timer_q;
        if (!enable) begin
            fsm_d = S_IDLE;
        end else begin
            case (fsm_q)
                S_IDLE, S_FWD, S_TURN_L, S_TURN_R: begin
                    case (dec)
                        P_FWD:    fsm_d = S_FWD;
                        P_TURN_L: fsm_d = S_TURN_L;
                        P_TURN_R: fsm_d = S_TURN_R;
                        P_LOST: begin
                            fsm_d   = S_SEARCH;
                            timer_d = '0;
                        end
                        default: ;
                    endcase
                end
                S_SEARCH: begin
                    case (dec)
                        P_FWD:    begin fsm_d = S_FWD;    timer_d = '0; end
                        P_TURN_L: begin fsm_d = S_TURN_L; timer_d = '0; end
                        P_TURN_R: begin fsm_d = S_TURN_R; timer_d = '0; end
                        P_LOST: begin
                            if (timer_q == TMR_LAST)
                                fsm_d = S_HALT;
                            else
                                timer_d = timer_q + 1'b1;
                        end
                        // A crossing pattern keeps searching; the timer saturates.
                        default: if (timer_q != TMR_LAST) timer_d = timer_q + 1'b1;
                    endcase
                end
                S_HALT:  ;
                default: fsm_d = S_IDLE;
            endcase
        end
        if (fsm_d == S_TURN_L)
            dir_left_d = 1'b1;
        else if (fsm_d == S_TURN_R)
            dir_left_d = 1'b0;
    end

    // Action code and target duties for the state being entered.
    logic [1:0]       state_d;
    logic [DTY_W-1:0] duty_l_d, duty_r_d;

    always_comb begin
        state_d  = 2'b00;
        duty_l_d = '0;
        duty_r_d = '0;
        case (fsm_d)
            S_FWD:    begin state_d = 2'b11; duty_l_d = D_FWD;  duty_r_d = D_FWD;  end
            S_TURN_L: begin state_d = 2'b01; duty_l_d = D_SLOW; duty_r_d = D_FAST; end
            S_TURN_R: begin state_d = 2'b10; duty_l_d = D_FAST; duty_r_d = D_SLOW; end
            S_SEARCH: begin
                if (dir_left_d) begin state_d = 2'b01; duty_r_d = D_SRCH; end
                else            begin state_d = 2'b10; duty_l_d = D_SRCH; end
            end
            default: ;
        endcase
    end

    // ---------------- registered FSM, outputs and PWM ----------------
    logic [1:0]       state_q;
    logic             lost_q;
    logic [CNT_W-1:0] pwm_cnt_q;
    logic [DTY_W-1:0] duty_l_q, duty_r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= S_IDLE;
            dir_left_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= '0;
            lost_q     <= 1'b0;
            pwm_cnt_q  <= '0;
            duty_l_q   <= '0;
            duty_r_q   <= '0;
        end else begin
            fsm_q      <= fsm_d;
            dir_left_q <= dir_left_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
            lost_q     <= (fsm_d == S_HALT);
            pwm_cnt_q  <= (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
            // Stopping takes effect at once; any other change waits for the period wrap.
            if (fsm_d == S_IDLE || fsm_d == S_HALT) begin
                duty_l_q <= '0;
                duty_r_q <= '0;
            end else if (pwm_cnt_q == CNT_LAST) begin
                duty_l_q <= duty_l_d;
                duty_r_q <= duty_r_d;
            end
        end
    end

    assign state        = state_q;
    assign lost         = lost_q;
    assign line_pattern = pattern_q;
    assign left_pwm     = ({1'b0, pwm_cnt_q} < duty_l_q);
    assign right_pwm    = ({1'b0, pwm_cnt_q} < duty_r_q);

endmodule
